// File: rtl/cp0_excpt_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception flag bits, ExcCodes and field positions,
// plus the single-event priority selector used by the exception controller.
package cp0_excpt_ctrl_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int EXC_ADEL_BIT = 4;
    localparam int EXC_SYS_BIT  = 8;
    localparam int EXC_ERET_BIT = 9;
    localparam int EXC_RI_BIT   = 10;
    localparam int EXC_OV_BIT   = 12;

    typedef enum logic [4:0] {
        CODE_INT  = 5'd0,
        CODE_ADEL = 5'd4,
        CODE_SYS  = 5'd8,
        CODE_RI   = 5'd10,
        CODE_OV   = 5'd12
    } exc_code_e;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_SW_LO  = 8;
    localparam int CA_SW_HI  = 9;
    localparam int CA_HW_LO  = 10;
    localparam int CA_HW_HI  = 15;
    localparam int CA_WP     = 22;
    localparam int CA_IV     = 23;
    localparam int CA_BD     = 31;

    localparam logic [31:0] STATUS_RST = 32'h1000_0000;

    typedef enum logic [2:0] {
        EV_NONE, EV_INT, EV_ADEL, EV_RI, EV_OV, EV_SYS, EV_ERET
    } event_e;

    // Exactly one event wins per cycle; everything below it is dropped.
    function automatic event_e pick_event(input logic int_req, input logic [31:0] exc);
        if (int_req)                 return EV_INT;
        else if (exc[EXC_ADEL_BIT])  return EV_ADEL;
        else if (exc[EXC_RI_BIT])    return EV_RI;
        else if (exc[EXC_OV_BIT])    return EV_OV;
        else if (exc[EXC_SYS_BIT])   return EV_SYS;
        else if (exc[EXC_ERET_BIT])  return EV_ERET;
        else                         return EV_NONE;
    endfunction

endpackage

// File: rtl/cp0_excpt_ctrl_if.sv
// Pipeline <-> CP0 signal bundle: mtc0/mfc0 access, MEM-stage exception info and the redirect.
interface cp0_excpt_ctrl_if #(
    parameter int NUM_HW_INT = 6
);
    logic                  cp0we;
    logic [4:0]            cp0Addr;
    logic [31:0]           cp0wData;
    logic [31:0]           cp0rData;
    logic [NUM_HW_INT-1:0] intr;
    logic [31:0]           excptype;
    logic [31:0]           pc;
    logic                  inDelaySlot;
    logic [31:0]           badAddr;
    logic                  flush;
    logic [31:0]           excVector;
    logic                  intimer;
    logic [31:0]           status;
    logic [31:0]           cause;
    logic [31:0]           epc;

    modport master (
        output cp0we, cp0Addr, cp0wData, intr, excptype, pc, inDelaySlot, badAddr,
        input  cp0rData, flush, excVector, intimer, status, cause, epc
    );

    modport slave (
        input  cp0we, cp0Addr, cp0wData, intr, excptype, pc, inDelaySlot, badAddr,
        output cp0rData, flush, excVector, intimer, status, cause, epc
    );
endinterface

// File: rtl/cp0_excpt_ctrl_timer.sv
// Count/Compare pair with the sticky timer-pending flag; intimer_next lets Cause.IP
// pick up the timer in the same edge that sets the flag.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cnt_we,
    input  logic        cmp_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        intimer,
    output logic        intimer_next
);
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        intimer_q, intimer_d;

    always_comb begin
        count_d   = cnt_we ? wdata : count_q + 32'd1;
        compare_d = cmp_we ? wdata : compare_q;
        intimer_d = intimer_q;
        if (compare_q != 32'd0 && count_d == compare_q)
            intimer_d = 1'b1;
        // A Compare write acknowledges the timer even if it matches this cycle.
        if (cmp_we)
            intimer_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            intimer_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            intimer_q <= intimer_d;
        end
    end

    assign count        = count_q;
    assign compare      = compare_q;
    assign intimer      = intimer_q;
    assign intimer_next = intimer_d;
endmodule

// File: rtl/cp0_excpt_ctrl.sv
// CP0 register file, interrupt masking, prioritised exception entry/eret and the registered
// flush/redirect back to fetch.
module cp0_excpt_ctrl
    import cp0_excpt_ctrl_pkg::*;
#(
    parameter int          NUM_HW_INT       = 6,
    parameter int          TIMER_IP         = 7,
    parameter logic [31:0] EXC_VECTOR       = 32'h0000_0040,
    parameter bit          SYSCALL_RET_NEXT = 1'b1
) (
    input logic              clk,
    input logic              rst,
    cp0_excpt_ctrl_if.slave  bus
);
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        flush_q, flush_d;
    logic [31:0] exc_vector_q, exc_vector_d;

    logic [31:0] count, compare;
    logic        intimer, intimer_next;
    logic        cnt_we, cmp_we;
    logic        int_req;
    logic [5:0]  ip_hw;
    event_e      ev;
    exc_code_e   code;

    assign cnt_we = bus.cp0we && (bus.cp0Addr == REG_COUNT);
    assign cmp_we = bus.cp0we && (bus.cp0Addr == REG_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .cnt_we       (cnt_we),
        .cmp_we       (cmp_we),
        .wdata        (bus.cp0wData),
        .count        (count),
        .compare      (compare),
        .intimer      (intimer),
        .intimer_next (intimer_next)
    );

    assign int_req = (|(cause_q[15:8] & status_q[15:8])) & status_q[ST_IE]
                     & ~status_q[ST_EXL] & ~flush_q;

    always_comb begin
        status_d     = status_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        badvaddr_d   = badvaddr_q;
        flush_d      = 1'b0;
        exc_vector_d = exc_vector_q;
        code         = CODE_INT;

        ip_hw = 6'(bus.intr);
        ip_hw[TIMER_IP-2] = ip_hw[TIMER_IP-2] | intimer_next;
        cause_d[CA_HW_HI:CA_HW_LO] = ip_hw;

        if (bus.cp0we) begin
            case (bus.cp0Addr)
                REG_STATUS: status_d = bus.cp0wData;
                REG_CAUSE: begin
                    cause_d[CA_SW_HI:CA_SW_LO] = bus.cp0wData[CA_SW_HI:CA_SW_LO];
                    cause_d[CA_IV]             = bus.cp0wData[CA_IV];
                    cause_d[CA_WP]             = bus.cp0wData[CA_WP];
                end
                REG_EPC:    epc_d = bus.cp0wData;
                default: ;
            endcase
        end

        // Instructions in MEM during the flush cycle are already killed.
        ev = pick_event(int_req, flush_q ? 32'd0 : bus.excptype);

        case (ev)
            EV_INT:  code = CODE_INT;
            EV_ADEL: code = CODE_ADEL;
            EV_RI:   code = CODE_RI;
            EV_OV:   code = CODE_OV;
            EV_SYS:  code = CODE_SYS;
            default: code = CODE_INT;
        endcase

        if (ev == EV_ERET) begin
            status_d[ST_EXL] = 1'b0;
            flush_d          = 1'b1;
            exc_vector_d     = epc_q;
        end else if (ev != EV_NONE) begin
            cause_d[CA_EXC_HI:CA_EXC_LO] = code;
            // A nested exception keeps the outer handler's return state.
            if (!status_q[ST_EXL]) begin
                if (bus.inDelaySlot) begin
                    epc_d          = bus.pc - 32'd4;
                    cause_d[CA_BD] = 1'b1;
                end else begin
                    epc_d          = (ev == EV_SYS && SYSCALL_RET_NEXT) ? bus.pc + 32'd4 : bus.pc;
                    cause_d[CA_BD] = 1'b0;
                end
            end
            status_d[ST_EXL] = 1'b1;
            if (ev == EV_ADEL)
                badvaddr_d = bus.badAddr;
            flush_d      = 1'b1;
            exc_vector_d = EXC_VECTOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q     <= STATUS_RST;
            cause_q      <= 32'd0;
            epc_q        <= 32'd0;
            badvaddr_q   <= 32'd0;
            flush_q      <= 1'b0;
            exc_vector_q <= 32'd0;
        end else begin
            status_q     <= status_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
            badvaddr_q   <= badvaddr_d;
            flush_q      <= flush_d;
            exc_vector_q <= exc_vector_d;
        end
    end

    always_comb begin
        case (bus.cp0Addr)
            REG_BADVADDR: bus.cp0rData = badvaddr_q;
            REG_COUNT:    bus.cp0rData = count;
            REG_COMPARE:  bus.cp0rData = compare;
            REG_STATUS:   bus.cp0rData = status_q;
            REG_CAUSE:    bus.cp0rData = cause_q;
            REG_EPC:      bus.cp0rData = epc_q;
            default:      bus.cp0rData = 32'd0;
        endcase
    end

    assign bus.flush     = flush_q;
    assign bus.excVector = exc_vector_q;
    assign bus.intimer   = intimer;
    assign bus.status    = status_q;
    assign bus.cause     = cause_q;
    assign bus.epc       = epc_q;
endmodule

// File: tb/tb_cp0_excpt_ctrl.sv
// Bench for cp0_excpt_ctrl: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the CP0 rules.
module tb_cp0_excpt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam int PRIO [5] = '{4, 10, 12, 8, 9};

    always #5 clk = ~clk;

    cp0_excpt_ctrl_if #(.NUM_HW_INT(6)) bus ();

    cp0_excpt_ctrl #(
        .NUM_HW_INT(6), .TIMER_IP(7), .EXC_VECTOR(32'h40), .SYSCALL_RET_NEXT(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] m_count, m_cmp, m_status, m_cause, m_epc, m_bad, m_vec;
    logic        m_tim, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_cmp = 0; m_tim = 0;
        m_status = 32'h1000_0000; m_cause = 0; m_epc = 0; m_bad = 0;
        m_flush = 0; m_vec = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_cmp;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] cnt_n, cmp_n, st_n, ca_n, epc_n, bad_n, vec_n, exc;
        logic [5:0]  hw;
        logic        tim_n, ireq, entry, eret;
        int          code;
        if (!rst) begin
            model_reset();
            return;
        end
        cnt_n = (bus.cp0we && bus.cp0Addr == 9)  ? bus.cp0wData : m_count + 32'd1;
        cmp_n = (bus.cp0we && bus.cp0Addr == 11) ? bus.cp0wData : m_cmp;
        tim_n = m_tim;
        if (m_cmp != 0 && cnt_n == m_cmp) tim_n = 1'b1;
        if (bus.cp0we && bus.cp0Addr == 11) tim_n = 1'b0;
        hw = bus.intr;
        if (tim_n) hw[5] = 1'b1;
        ireq = ((m_cause[15:8] & m_status[15:8]) != 0) && m_status[0] && !m_status[1] && !m_flush;
        st_n = m_status; epc_n = m_epc; bad_n = m_bad; vec_n = m_vec;
        ca_n = {m_cause[31:16], hw, m_cause[9:0]};
        if (bus.cp0we) begin
            if (bus.cp0Addr == 12) st_n = bus.cp0wData;
            if (bus.cp0Addr == 14) epc_n = bus.cp0wData;
            if (bus.cp0Addr == 13) begin
                ca_n[9:8]   = bus.cp0wData[9:8];
                ca_n[23:22] = bus.cp0wData[23:22];
            end
        end
        exc = m_flush ? 32'd0 : bus.excptype;
        entry = 1'b0; eret = 1'b0; code = 0;
        if (ireq) entry = 1'b1;
        else begin
            for (int k = 0; k < 5; k++) begin
                if (exc[PRIO[k]]) begin
                    if (PRIO[k] == 9) eret = 1'b1;
                    else begin entry = 1'b1; code = PRIO[k]; end
                    break;
                end
            end
        end
        if (entry) begin
            ca_n[6:2] = code[4:0];
            if (!m_status[1]) begin
                if (bus.inDelaySlot) begin epc_n = bus.pc - 4; ca_n[31] = 1'b1; end
                else begin epc_n = (code == 8) ? bus.pc + 4 : bus.pc; ca_n[31] = 1'b0; end
            end
            st_n[1] = 1'b1;
            if (code == 4) bad_n = bus.badAddr;
            vec_n = 32'h40;
        end
        if (eret) begin
            st_n[1] = 1'b0;
            vec_n = m_epc;
        end
        m_count = cnt_n; m_cmp = cmp_n; m_tim = tim_n;
        m_status = st_n; m_cause = ca_n; m_epc = epc_n; m_bad = bad_n;
        m_flush = entry | eret; m_vec = vec_n;
    endtask

    task automatic cycle();
        #1;
        chk("rdata", bus.cp0rData, m_read(bus.cp0Addr));
        @(posedge clk);
        model_step();
        #1;
        chk("status", bus.status, m_status);
        chk("cause", bus.cause, m_cause);
        chk("epc", bus.epc, m_epc);
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("intimer", 32'(bus.intimer), 32'(m_tim));
        if (m_flush) chk("excVector", bus.excVector, m_vec);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0we = 1'b1; bus.cp0Addr = a; bus.cp0wData = d;
        cycle();
        bus.cp0we = 1'b0;
    endtask

    initial begin
        bus.cp0we = 0; bus.cp0Addr = 0; bus.cp0wData = 0; bus.intr = 0;
        bus.excptype = 0; bus.pc = 0; bus.inDelaySlot = 0; bus.badAddr = 0;

        // Reset
        rst = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_status", bus.status, 32'h1000_0000);
        chk("rst_cause", bus.cause, 32'd0);
        chk("rst_epc", bus.epc, 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_intimer", 32'(bus.intimer), 32'd0);
        rst = 1'b1;

        // Timer interrupt
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        mtc0(5'd12, 32'h1000_8001);
        for (int i = 0; i < 40 && !bus.flush; i++) cycle();
        chk("t2_flush", 32'(bus.flush), 32'd1);
        chk("t2_intimer", 32'(bus.intimer), 32'd1);
        chk("t2_code", 32'(bus.cause[6:2]), 32'd0);
        chk("t2_exl", 32'(bus.status[1]), 32'd1);
        chk("t2_vec", bus.excVector, 32'h40);
        mtc0(5'd11, 32'd100000);
        chk("t2_clr", 32'(bus.intimer), 32'd0);

        // Delay-slot and plain syscall
        mtc0(5'd12, 32'h1000_0000);
        bus.excptype = 32'h100; bus.pc = 32'h1000; bus.inDelaySlot = 1;
        cycle();
        chk("t3_epc_ds", bus.epc, 32'h0FFC);
        chk("t3_bd", 32'(bus.cause[31]), 32'd1);
        chk("t3_code", 32'(bus.cause[6:2]), 32'd8);
        chk("t3_vec", bus.excVector, 32'h40);
        bus.excptype = 0; bus.inDelaySlot = 0;
        cycle();
        mtc0(5'd12, 32'h1000_0000);
        bus.excptype = 32'h100;
        cycle();
        chk("t3_epc", bus.epc, 32'h1004);
        chk("t3_bd0", 32'(bus.cause[31]), 32'd0);
        bus.excptype = 0;
        cycle();

        // Interrupt beats RI
        bus.intr = 6'd1;
        mtc0(5'd12, 32'h1000_0401);
        bus.excptype = 32'h400; bus.pc = 32'h3000;
        cycle();
        chk("t4_code", 32'(bus.cause[6:2]), 32'd0);
        chk("t4_flush", 32'(bus.flush), 32'd1);
        chk("t4_epc", bus.epc, 32'h3000);
        bus.excptype = 0;
        cycle();

        // Nested Ov, masked interrupt
        bus.excptype = 32'h1000; bus.pc = 32'h2000;
        cycle();
        chk("t5_code", 32'(bus.cause[6:2]), 32'd12);
        chk("t5_epc", bus.epc, 32'h3000);
        chk("t5_flush", 32'(bus.flush), 32'd1);
        bus.excptype = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_masked", 32'(bus.flush), 32'd0);
        end
        bus.intr = 0;

        // Eret racing mtc0 EPC
        mtc0(5'd14, 32'h300);
        bus.excptype = 32'h200;
        mtc0(5'd14, 32'h500);
        chk("t6_vec", bus.excVector, 32'h300);
        chk("t6_flush", 32'(bus.flush), 32'd1);
        chk("t6_epc", bus.epc, 32'h500);
        chk("t6_exl", 32'(bus.status[1]), 32'd0);
        bus.excptype = 0;
        cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] regs [7];
            int sel;
            regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
            rst = ($urandom_range(0, 299) != 0);
            bus.cp0we = ($urandom_range(0, 3) == 0);
            bus.cp0Addr = regs[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) bus.cp0Addr = 5'($urandom);
            bus.cp0wData = $urandom;
            if (bus.cp0Addr == 5'd11 && $urandom_range(0, 1) == 1)
                bus.cp0wData = m_count + 32'($urandom_range(1, 8));
            if ($urandom_range(0, 7) == 0) bus.intr = 6'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 5) bus.excptype = 32'd1 << PRIO[sel];
            else if (sel == 5) bus.excptype = $urandom;
            else bus.excptype = 32'd0;
            bus.pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            bus.inDelaySlot = 1'($urandom);
            bus.badAddr = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
